// File: rtl/wb_slave_switch.sv
// wb_slave_switch
//   Single-master Wishbone classic switch. Decodes each master cycle to one
//   of NSLV slaves by base/mask match in memory space (tga=0) or IO space
//   (tga=1). It latches the request and broadcasts it to all slaves, and
//   strobes only the selected slave. The selected slave's data and ack are
//   registered back to the master.
//   The switch answers some cycles itself:
//     - unmapped accesses return DEF_DAT with err=1;
//     - interrupt-acknowledge cycles return INTA_VEC with err=0;
//     - a slave that does not ack within TO_CYCLES returns all-ones with
//       err=1.
//
// Ports
//   wb_clk_i             system clock
//   wb_rst_i             asynchronous, active-low reset
//   m_adr_i .. m_cyc_i   master request (address, data, we, sel, tga, tgc,
//                        stb, cyc)
//   m_dat_o              registered read data; holds until the next ack
//   m_ack_o              one-cycle ack pulse
//   m_err_o              qualifies m_ack_o: unmapped or timed out
//   s_adr_o .. s_tga_o   latched request, broadcast to all slaves
//   s_stb_o              one-hot slave strobe (also used as slave cyc)
//   s_dat_i              slave read data; slave i at [i*DW +: DW]
//   s_ack_i              slave acks
module wb_slave_switch #(
  parameter int unsigned           NSLV      = 4,
  parameter int unsigned           AW        = 19,
  parameter int unsigned           DW        = 16,
  parameter logic [NSLV*AW-1:0]    SLV_BASE  = '0,
  parameter logic [NSLV*AW-1:0]    SLV_MASK  = '0,
  parameter logic [NSLV-1:0]       SLV_IO    = '0,
  parameter int unsigned           TO_CYCLES = 255,
  parameter int unsigned           TOW       = 8,
  parameter logic [DW-1:0]         DEF_DAT   = 16'h0000,
  parameter logic [DW-1:0]         INTA_VEC  = 16'h0009
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [DW-1:0]        m_dat_i,
  input  logic                 m_we_i,
  input  logic [1:0]           m_sel_i,
  input  logic                 m_tga_i,
  input  logic                 m_tgc_i,
  input  logic                 m_stb_i,
  input  logic                 m_cyc_i,
  output logic [DW-1:0]        m_dat_o,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic                 s_we_o,
  output logic [1:0]           s_sel_o,
  output logic                 s_tga_o,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [NSLV*DW-1:0]   s_dat_i,
  input  logic [NSLV-1:0]      s_ack_i
);

  localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  // Last counter value of the ACTIVE window; meaningless when TO_CYCLES=0.
  localparam logic [TOW-1:0] TO_LAST = (TO_CYCLES == 0) ? '0 : TOW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ACK} state_t;

  state_t          state;
  logic [IW-1:0]   idx_q;
  logic [TOW-1:0]  cnt_q;

  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [NSLV-1:0] hit_oh;
  logic            sel_ack;
  logic [DW-1:0]   sel_dat;
  logic            to_hit;
  logic            req;

  assign req = m_stb_i & m_cyc_i;

  // Address decode on the live master inputs. Lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!hit &&
          (((m_adr_i ^ SLV_BASE[i*AW +: AW]) & SLV_MASK[i*AW +: AW]) == '0) &&
          (m_tga_i == SLV_IO[i])) begin
        hit       = 1'b1;
        hit_idx   = IW'(i);
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Return path from the latched slave only. Acks from other slaves are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ack = s_ack_i[i];
        sel_dat = s_dat_i[i*DW +: DW];
      end
    end
  end

  assign to_hit = (TO_CYCLES != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state   <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_we_o  <= 1'b0;
      s_sel_o <= '0;
      s_tga_o <= 1'b0;
      s_stb_o <= '0;
    end else begin
      m_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            s_adr_o <= m_adr_i;
            s_dat_o <= m_dat_i;
            s_we_o  <= m_we_i;
            s_sel_o <= m_sel_i;
            s_tga_o <= m_tga_i;
            if (m_tgc_i) begin
              m_dat_o <= INTA_VEC;
              m_err_o <= 1'b0;
              m_ack_o <= 1'b1;
              state   <= ACK;
            end else if (hit) begin
              idx_q   <= hit_idx;
              s_stb_o <= hit_oh;
              cnt_q   <= '0;
              state   <= ACTIVE;
            end else begin
              m_dat_o <= DEF_DAT;
              m_err_o <= 1'b1;
              m_ack_o <= 1'b1;
              state   <= ACK;
            end
          end
        end
        ACTIVE: begin
          if (!req) begin
            // Master abandoned the cycle: no ack is returned.
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (sel_ack) begin
            m_dat_o <= sel_dat;
            m_err_o <= 1'b0;
            m_ack_o <= 1'b1;
            s_stb_o <= '0;
            state   <= ACK;
          end else if (to_hit) begin
            m_dat_o <= '1;
            m_err_o <= 1'b1;
            m_ack_o <= 1'b1;
            s_stb_o <= '0;
            state   <= ACK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACK: begin
          m_err_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_switch.sv
module tb_wb_slave_switch;

  localparam int TO = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic [18:0] m_adr_i  = '0;
  logic [15:0] m_dat_i  = '0;
  logic        m_we_i   = 1'b0;
  logic [1:0]  m_sel_i  = '0;
  logic        m_tga_i  = 1'b0;
  logic        m_tgc_i  = 1'b0;
  logic        m_stb_i  = 1'b0;
  logic        m_cyc_i  = 1'b0;
  logic [15:0] m_dat_o;
  logic        m_ack_o;
  logic        m_err_o;
  logic [18:0] s_adr_o;
  logic [15:0] s_dat_o;
  logic        s_we_o;
  logic [1:0]  s_sel_o;
  logic        s_tga_o;
  logic [1:0]  s_stb_o;
  logic [31:0] s_dat_i  = '0;
  logic [1:0]  s_ack_i;

  wb_slave_switch #(
    .NSLV      (2),
    .AW        (19),
    .DW        (16),
    .SLV_BASE  ({19'h07000, 19'h5C000}),
    .SLV_MASK  ({19'h07F00, 19'h7F800}),
    .SLV_IO    (2'b10),
    .TO_CYCLES (TO),
    .TOW       (8),
    .DEF_DAT   (16'h0000),
    .INTA_VEC  (16'h0009)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_we_i   (m_we_i),
    .m_sel_i  (m_sel_i),
    .m_tga_i  (m_tga_i),
    .m_tgc_i  (m_tgc_i),
    .m_stb_i  (m_stb_i),
    .m_cyc_i  (m_cyc_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_tga_o  (s_tga_o),
    .s_stb_o  (s_stb_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave behaviour: slave i acks on strobe cycle ack_at[i] (0 = never).
  // spur[] injects acks on slaves the reference says are not selected.
  int          ack_at[2] = '{0, 0};
  int          scnt[2]   = '{0, 0};
  logic [1:0]  spur      = '0;
  logic [1:0]  exp_oh    = '0;

  always @(posedge wb_clk_i)
    for (int i = 0; i < 2; i++) scnt[i] <= s_stb_o[i] ? scnt[i] + 1 : 0;

  always_comb
    for (int i = 0; i < 2; i++)
      s_ack_i[i] = (s_stb_o[i] && ack_at[i] != 0 && scnt[i] + 1 == ack_at[i]) ||
                   (spur[i] && !exp_oh[i]);

  // Reference decode table.
  logic [18:0] ref_base[2] = '{19'h5C000, 19'h07000};
  logic [18:0] ref_mask[2] = '{19'h7F800, 19'h07F00};
  logic        ref_io[2]   = '{1'b0, 1'b1};

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: which slave, when the ack comes, what it carries.
  function automatic void model(input logic [18:0] adr, input logic tga, input logic tgc,
                                input int a0, input int a1,
                                input logic [15:0] d0, input logic [15:0] d1,
                                output int e_cyc, output logic [15:0] e_dat,
                                output logic e_err, output logic [1:0] e_oh,
                                output int e_stb);
    int t;
    int k;
    t = -1;
    e_oh = '0;
    if (tgc) begin
      e_cyc = 1; e_dat = 16'h0009; e_err = 1'b0; e_stb = 0;
      return;
    end
    for (int i = 1; i >= 0; i--)
      if (((adr & ref_mask[i]) == (ref_base[i] & ref_mask[i])) && tga == ref_io[i]) t = i;
    if (t < 0) begin
      e_cyc = 1; e_dat = 16'h0000; e_err = 1'b1; e_stb = 0;
      return;
    end
    e_oh[t] = 1'b1;
    k = (t == 0) ? a0 : a1;
    if (k >= 1 && k <= TO) begin
      e_cyc = k + 1; e_dat = (t == 0) ? d0 : d1; e_err = 1'b0; e_stb = k;
    end else begin
      e_cyc = TO + 1; e_dat = 16'hFFFF; e_err = 1'b1; e_stb = TO;
    end
  endfunction

  task automatic run_txn(input string nm, input logic [18:0] adr, input logic [15:0] dat,
                         input logic we, input logic [1:0] sel, input logic tga,
                         input logic tgc, input int a0, input int a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [1:0] sp);
    int          e_cyc;
    logic [15:0] e_dat;
    logic        e_err;
    logic [1:0]  e_oh;
    int          e_stb;
    int          got_cyc;
    logic [15:0] got_dat;
    logic        got_err;
    int          stb_n;
    logic [1:0]  stb_seen;
    model(adr, tga, tgc, a0, a1, d0, d1, e_cyc, e_dat, e_err, e_oh, e_stb);
    @(negedge wb_clk_i);
    ack_at[0] = a0; ack_at[1] = a1;
    s_dat_i = {d1, d0};
    exp_oh = e_oh; spur = sp;
    m_adr_i = adr; m_dat_i = dat; m_we_i = we; m_sel_i = sel;
    m_tga_i = tga; m_tgc_i = tgc; m_stb_i = 1'b1; m_cyc_i = 1'b1;
    got_cyc = 0; got_dat = '0; got_err = 1'b0; stb_n = 0; stb_seen = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge wb_clk_i); #1;
      if (c == 1) begin
        chk({nm, ".s_adr"}, 32'(s_adr_o), 32'(adr));
        chk({nm, ".s_dat"}, 32'(s_dat_o), 32'(dat));
        chk({nm, ".s_we"},  32'(s_we_o),  32'(we));
        chk({nm, ".s_sel"}, 32'(s_sel_o), 32'(sel));
        chk({nm, ".s_tga"}, 32'(s_tga_o), 32'(tga));
        chk({nm, ".stb_c1"}, 32'(s_stb_o), 32'(e_oh));
        // Scramble master inputs: outputs must stay latched.
        m_adr_i = 19'($urandom); m_dat_i = 16'($urandom);
        m_we_i = 1'($urandom); m_sel_i = 2'($urandom);
        m_tga_i = 1'($urandom); m_tgc_i = 1'($urandom);
      end
      if (s_stb_o != 0) begin
        stb_n++;
        stb_seen |= s_stb_o;
      end
      if (m_ack_o) begin
        got_cyc = c; got_dat = m_dat_o; got_err = m_err_o;
        m_stb_i = 1'b0; m_cyc_i = 1'b0; m_tgc_i = 1'b0;
        break;
      end
    end
    if (got_cyc == 0) begin
      m_stb_i = 1'b0; m_cyc_i = 1'b0; m_tgc_i = 1'b0;
    end
    chk({nm, ".ack_cyc"},  32'(got_cyc), 32'(e_cyc));
    chk({nm, ".dat"},      32'(got_dat), 32'(e_dat));
    chk({nm, ".err"},      32'(got_err), 32'(e_err));
    chk({nm, ".stb_n"},    32'(stb_n),   32'(e_stb));
    chk({nm, ".stb_seen"}, 32'(stb_seen), 32'(e_oh));
    @(posedge wb_clk_i); #1;
    chk({nm, ".ack_pulse"}, 32'(m_ack_o), 32'd0);
    chk({nm, ".dat_hold"},  32'(m_dat_o), 32'(e_dat));
    chk({nm, ".adr_hold"},  32'(s_adr_o), 32'(adr));
  endtask

  initial begin
    // Reset state.
    wb_rst_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst.m_dat", 32'(m_dat_o), 32'd0);
    chk("rst.m_ack", 32'(m_ack_o), 32'd0);
    chk("rst.m_err", 32'(m_err_o), 32'd0);
    chk("rst.s_stb", 32'(s_stb_o), 32'd0);
    chk("rst.s_adr", 32'(s_adr_o), 32'd0);
    chk("rst.s_dat", 32'(s_dat_o), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;

    // Directed cases.
    run_txn("memrd",  19'h5C010, 16'h1234, 1'b0, 2'b11, 1'b0, 1'b0, 1, 0, 16'h0741, 16'hBEEF, 2'b00);
    run_txn("iowr",   19'h07004, 16'hA5A5, 1'b1, 2'b11, 1'b1, 1'b0, 0, 3, 16'h1111, 16'h2222, 2'b00);
    run_txn("unmap",  19'h00100, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b0, 1, 1, 16'h3333, 16'h4444, 2'b00);
    run_txn("inta",   19'h5C000, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b1, 1, 1, 16'h5555, 16'h6666, 2'b00);
    run_txn("tmo",    19'h5C7FE, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 0, 0, 16'h7777, 16'h8888, 2'b10);
    run_txn("ack4",   19'h5C000, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 4, 0, 16'hC0DE, 16'h8888, 2'b10);
    run_txn("spur",   19'h07F00, 16'h0F0F, 1'b1, 2'b10, 1'b1, 1'b0, 0, 2, 16'h9999, 16'h0102, 2'b01);

    // Reset asserted mid-ACTIVE.
    @(negedge wb_clk_i);
    ack_at[0] = 0; ack_at[1] = 0; spur = '0; exp_oh = 2'b01;
    m_adr_i = 19'h5C010; m_tga_i = 1'b0; m_tgc_i = 1'b0; m_we_i = 1'b0;
    m_stb_i = 1'b1; m_cyc_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("rstmid.stb_before", 32'(s_stb_o), 32'd1);
    @(posedge wb_clk_i); #3;
    wb_rst_i = 1'b0;
    #1;
    chk("rstmid.stb_now", 32'(s_stb_o), 32'd0);
    chk("rstmid.ack_now", 32'(m_ack_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge wb_clk_i); #1;
      chk("rstmid.no_ack", 32'(m_ack_o), 32'd0);
    end
    m_stb_i = 1'b0; m_cyc_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    run_txn("post_rst", 19'h5C010, 16'h0000, 1'b0, 2'b11, 1'b0, 1'b0, 2, 0, 16'h0741, 16'h0000, 2'b00);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [18:0] adr;
      logic        tga;
      logic        tgc;
      int          mode;
      mode = int'($urandom_range(0, 3));
      adr  = 19'($urandom);
      tga  = 1'($urandom);
      tgc  = 1'b0;
      case (mode)
        0: begin adr = 19'h5C000 | (adr & 19'h007FF); tga = 1'b0; end
        1: begin adr = (adr & ~19'h07F00) | 19'h07000; tga = 1'b1; end
        2: ;
        default: tgc = ($urandom_range(0, 1) == 1);
      endcase
      run_txn("rnd", adr, 16'($urandom), 1'($urandom), 2'($urandom), tga, tgc,
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
              16'($urandom), 16'($urandom), 2'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_slave_switch.md
Name: wb_slave_switch

Overview:
- Parametrised single-master Wishbone classic switch that replaces hand-written per-device arena decode, data/ack muxing and ad-hoc defaults in the top level.
- Decodes master cycles to one of NSLV slaves by base/mask match in memory space (tga=0) or IO space (tga=1).
- Registers the broadcast request, muxes the selected slave's data and ack back to the master, and answers unmapped accesses itself.
- Adds behaviour the top level lacks: a per-cycle ack timeout with error flag, and interrupt-acknowledge vector return.

Parameters:
- NSLV, 4, number of slave channels (1..8)
- AW, 19, word address width (adr[19:1])
- DW, 16, data width
- SLV_BASE, 0, NSLV*AW packed; slave i base at [i*AW +: AW]
- SLV_MASK, 0, NSLV*AW packed; 1 = address bit compared
- SLV_IO, 0, NSLV bits; 1 = slave decodes IO space (tga=1), 0 = memory space
- TO_CYCLES, 255, ACTIVE cycles before timeout; 0 disables the timeout
- TOW, 8, timeout counter width (must hold TO_CYCLES)
- DEF_DAT, 16'h0000, data returned for unmapped accesses
- INTA_VEC, 16'h0009, data returned for interrupt-acknowledge cycles

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous, active-low reset
- m_adr_i  in  AW  master address
- m_dat_i  in  DW  master write data
- m_we_i  in  1  master write enable
- m_sel_i  in  2  byte selects
- m_tga_i  in  1  1 = IO space
- m_tgc_i  in  1  interrupt-acknowledge cycle
- m_stb_i  in  1  master strobe
- m_cyc_i  in  1  master cycle
- m_dat_o  out  DW  read data (registered)
- m_ack_o  out  1  ack, one-cycle pulse (registered)
- m_err_o  out  1  qualifies m_ack_o: unmapped or timed out
- s_adr_o  out  AW  latched address, broadcast to all slaves
- s_dat_o  out  DW  latched write data, broadcast
- s_we_o  out  1  latched write enable
- s_sel_o  out  2  latched byte selects
- s_tga_o  out  1  latched tga
- s_stb_o  out  NSLV  one-hot strobe (also drives slave cyc)
- s_dat_i  in  NSLV*DW  slave read data, slave i at [i*DW +: DW]
- s_ack_i  in  NSLV  slave acks

Behaviour:
- Reset (wb_rst_i=0, asynchronous): state IDLE; all outputs 0; s_stb_o drops immediately, including mid-cycle; the timeout counter clears.
- Match: slave i matches when ((m_adr_i ^ SLV_BASE[i]) & SLV_MASK[i]) == 0 and m_tga_i == SLV_IO[i].
  - If several slaves match, the lowest index wins.
- FSM states: IDLE, ACTIVE, ACK.
- IDLE, m_stb_i & m_cyc_i:
  - Latch s_adr/dat/we/sel/tga_o.
  - m_tgc_i=1: go to ACK with m_dat_o=INTA_VEC, err=0; no slave is strobed.
  - Otherwise, a match exists: latch the slave index, set s_stb_o[idx]=1, clear the counter, go to ACTIVE.
  - Otherwise, no match: go to ACK with m_dat_o=DEF_DAT, err=1.
- ACTIVE:
  - s_ack_i[idx]=1: register s_dat_i[idx] into m_dat_o, err=0, drop s_stb_o, go to ACK.
  - Otherwise the counter increments. If TO_CYCLES≠0 and the counter equals TO_CYCLES-1 with no ack: m_dat_o=16'hFFFF, err=1, drop s_stb_o, go to ACK.
  - Ack and timeout in the same cycle: the ack wins.
  - Acks from non-selected slaves are ignored in every state.
- ACK: m_ack_o=1 and m_err_o valid for exactly one cycle, then IDLE unconditionally.
  - m_dat_o holds until the next ACK.
- Latency: request seen in IDLE at cycle 0; s_stb_o high in cycle 1; a combinational slave ack in cycle 1 gives m_ack_o in cycle 2.
  - Unmapped and INTA cycles ack in cycle 1.
- Master stb dropped while ACTIVE (abort): s_stb_o drops next edge, go to IDLE, no m_ack_o.
- Back-to-back: a master request present in the IDLE cycle after ACK starts a new transaction.
  - The master must deassert stb in the cycle after ack unless issuing a new cycle.
- Outputs s_* hold latched values from request start until the next request; they are not recomputed from live master inputs.

Test Plan:
- Config: NSLV=2.
  - Slave0: mem, base 19'h5C000, mask 19'h7F800.
  - Slave1: IO, base 19'h07000, mask 19'h07F00.
- Mem read adr=19'h5C010, slave0 acks in the first strobe cycle with 16'h0741 -> s_stb_o=2'b01 in cycle 1; m_ack_o pulse in cycle 2; m_dat_o=16'h0741; m_err_o=0.
- IO write tga=1, adr=19'h07004, dat=16'hA5A5, slave1 acks after 3 cycles -> s_stb_o=2'b10, s_dat_o=16'hA5A5, s_we_o=1; single m_ack_o; err=0.
- Unmapped read adr=19'h00100 tga=0 -> no s_stb_o; m_ack_o in cycle 1; m_dat_o=16'h0000; m_err_o=1.
- m_tgc_i=1 request -> m_ack_o in cycle 1; m_dat_o=16'h0009; no slave strobed.
- TO_CYCLES=4, slave0 never acks -> s_stb_o high exactly 4 cycles; then m_ack_o with m_dat_o=16'hFFFF, m_err_o=1.
  - Repeat with the ack arriving on cycle 4: ack wins, err=0.
- Assert wb_rst_i=0 mid-ACTIVE -> s_stb_o=0 immediately, no m_ack_o.
  - After release, a fresh request completes normally.
